addsub_serial_arbiter: RTL and testbench
========================================

# addsub_serial_arbiter

Shares a single 4-bit add/subtract slice between two requesters and sequences it nibble-serially to perform wide (4*NIBBLES-bit) unsigned/two's-complement add or subtract. A round-robin arbiter selects one requester per operation. Operands are shifted through the slice LSB-nibble first, with the carry chained across cycles. The result is returned on a valid/ready output port tagged with the requester ID. It sits between the integer-op issue logic and the small arithmetic datapath, so one slice serves both clients.

## Interface
- NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES); legal 2..16
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a, req0_b  input  W  requester 0 operands
- req0_sub  input  1  requester 0: 1 = a-b, 0 = a+b
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as requester 0, for requester 1
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- res_out  output  W  sum/difference
- res_carry  output  1  final carry out; for subtract 1 = no borrow (a >= b unsigned)
- res_ovf  output  1  signed overflow (carry into MSB xor carry out of MSB)
- res_id  output  1  requester that issued the result

## Operation
- One clock; reset is asynchronous and active-low.
- States: IDLE, RUN, DONE.
- IDLE: if any req*_valid, grant one requester. reqN_ready = (state==IDLE) & grantN, combinational. On the accept edge:
  - load a, b, sub and id into registers;
  - clear the nibble counter;
  - set carry register = sub;
  - go to RUN.
- Arbitration: round-robin pointer ptr (reset 0).
  - Both valid: grant ptr.
  - One valid: grant that one.
  - After any grant, ptr <= ~granted id.
- RUN: each cycle the slice computes nibble i.
  - Slice inputs: a[i], b[i]^{4{sub}}, carry register.
  - Sum nibble shifts into the result register from the MSB end.
  - Carry register <= slice carry out.
  - On the last nibble, capture ovf = carry into bit 3 xor carry out of bit 3.
  - After NIBBLES cycles go to DONE.
- DONE: res_valid = 1. res_out, res_carry, res_ovf and res_id are stable until res_ready. On res_valid & res_ready go to IDLE.
- Requesters must hold valid and operands until ready. Deasserting valid before ready is allowed and simply withdraws the request.
- No acceptance in RUN or DONE: both readys are 0.

## Timing
- Reset values:
  - state IDLE, ptr 0;
  - res_valid 0, res_out 0, res_carry 0, res_ovf 0, res_id 0;
  - req0_ready 0 and req1_ready 0 (no valid at reset).
- Latency: accept at edge E0; res_valid is high from edge E0+NIBBLES.
- Result handshake at edge Ek returns to IDLE. The earliest next accept is edge Ek+1, so peak throughput is one op per NIBBLES+2 cycles.
- res_ready held high on DONE entry: result is consumed on the first DONE edge.
- Reset asserted in any state: immediate return to reset values. The in-flight operation is discarded and never reported.
- Operands changing after acceptance have no effect.

## Test plan
- Reset: after rst_n release with no requests, all outputs are 0 and state stays IDLE for 10 cycles.
- Add, NIBBLES=4:
  - req0 0x1234+0x0FFF -> res_out 0x2233, carry 0, ovf 0, id 0, res_valid exactly 4 cycles after the accept edge.
  - 0xFFFF+0x0001 -> 0x0000, carry 1, ovf 0.
  - 0x7FFF+0x0001 -> 0x8000, carry 0, ovf 1.
- Subtract via req1:
  - 0x0005-0x0007 -> 0xFFFE, carry 0, ovf 0, id 1.
  - 0x8000-0x0001 -> 0x7FFF, carry 1, ovf 1.
  - 0x1234-0x1234 -> 0x0000, carry 1.
- Arbitration: both valid continuously for 6 ops with res_ready=1 -> res_id sequence 0,1,0,1,0,1, and each ready pulses for exactly one cycle per grant.
- Backpressure: res_ready=0 for 5 cycles in DONE -> outputs stay frozen, both readys stay 0, req0 still pending. Raising res_ready -> result consumed, then req0 is accepted one cycle later.
- Reset mid-op: assert rst_n low in RUN at nibble 2 -> res_valid never rises. After release with both valid, the first grant goes to req0.

Source files
------------

// File: rtl/addsub_serial_arbiter.sv
// ============================================================================
// Module   : addsub_serial_arbiter
// Brief    : Round-robin shared 4-bit add/sub slice, nibble-serial wide ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_serial_arbiter #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req0_sub,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req1_sub,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] res_out,
    output logic                 res_carry,
    output logic                 res_ovf,
    output logic                 res_id
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);

    localparam logic [1:0]    c_IDLE = 2'd0;
    localparam logic [1:0]    c_RUN  = 2'd1;
    localparam logic [1:0]    c_DONE = 2'd2;
    localparam logic [CW-1:0] c_LAST = CW'(NIBBLES - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic          r_ptr;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_res;
    logic          r_sub;
    logic          r_id;
    logic          r_carry;
    logic          r_ovf;
    logic [CW-1:0] r_cnt;

    logic          w_any;
    logic          w_gnt_id;
    logic          w_accept;
    logic [3:0]    w_bn;
    logic [4:0]    w_sum;
    logic [3:0]    w_low;
    logic          w_last;

    // Pointer only matters on a tie; a lone requester always wins.
    assign w_any    = req0_valid | req1_valid;
    assign w_gnt_id = (req0_valid & req1_valid) ? r_ptr : req1_valid;
    assign w_accept = req0_ready | req1_ready;
    assign w_last   = (r_cnt == c_LAST);

    // Subtract is a + ~b + 1: the +1 comes from the carry seeded at accept.
    assign w_bn  = r_b[3:0] ^ {4{r_sub}};
    assign w_sum = {1'b0, r_a[3:0]} + {1'b0, w_bn} + {4'b0, r_carry};
    assign w_low = {1'b0, r_a[2:0]} + {1'b0, w_bn[2:0]} + {3'b0, r_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_any)     w_next = c_RUN;
            c_RUN:   if (w_last)    w_next = c_DONE;
            c_DONE:  if (res_ready) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        case (r_state)
            c_IDLE: begin
                req0_ready = w_any & ~w_gnt_id;
                req1_ready = w_any & w_gnt_id;
            end
            c_DONE:  res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sub   <= 1'b0;
            r_id    <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= w_gnt_id ? req1_a   : req0_a;
            r_b     <= w_gnt_id ? req1_b   : req0_b;
            r_sub   <= w_gnt_id ? req1_sub : req0_sub;
            r_carry <= w_gnt_id ? req1_sub : req0_sub;
            r_id    <= w_gnt_id;
            r_ptr   <= ~w_gnt_id;
            r_cnt   <= '0;
        end else if (r_state == c_RUN) begin
            r_a     <= {4'b0, r_a[W-1:4]};
            r_b     <= {4'b0, r_b[W-1:4]};
            r_res   <= {w_sum[3:0], r_res[W-1:4]};
            r_carry <= w_sum[4];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_ovf <= w_low[3] ^ w_sum[4];
            end
        end
    end

    assign res_out   = r_res;
    assign res_carry = r_carry;
    assign res_ovf   = r_ovf;
    assign res_id    = r_id;

endmodule

`default_nettype wire

// File: tb/tb_addsub_serial_arbiter.sv
// ============================================================================
// Module   : tb_addsub_serial_arbiter
// Brief    : Directed self-checking bench for addsub_serial_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_serial_arbiter;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         res_valid, res_ready, res_carry, res_ovf, res_id;
    logic [W-1:0] res_out;

    int checks   = 0;
    int failures = 0;

    addsub_serial_arbiter #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_out    (res_out),
        .res_carry  (res_carry),
        .res_ovf    (res_ovf),
        .res_id     (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic id, input logic v, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic sub);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub;
        end
    endtask

    // Single op from one requester with exact latency and result checks.
    task automatic run_op(input string tag, input logic id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] e_out, input logic e_c, input logic e_v);
        @(negedge clk);
        drive_req(id, 1'b1, a, b, sub);
        #1;
        chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
        @(posedge clk);
        #1 drive_req(id, 1'b0, 16'hDEAD, 16'hBEEF, ~sub);
        for (int k = 0; k < NIB; k++) begin
            @(negedge clk);
            chk({tag, "_lat_lo"}, res_valid, 0);
        end
        @(negedge clk);
        chk({tag, "_lat_hi"}, res_valid, 1);
        chk({tag, "_out"},    res_out,   e_out);
        chk({tag, "_carry"},  res_carry, e_c);
        chk({tag, "_ovf"},    res_ovf,   e_v);
        chk({tag, "_id"},     res_id,    id);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_consumed"}, res_valid, 0);
    endtask

    int          nres;
    int          r0cnt, r1cnt;
    logic [5:0]  ids;
    int          wait_cnt;

    initial begin
        rst_n = 1'b0; res_ready = 1'b0;
        drive_req(1'b0, 1'b0, '0, '0, 1'b0);
        drive_req(1'b1, 1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state held with no requests.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_outs", {res_valid, res_carry, res_ovf, res_id, req0_ready, req1_ready}, 0);
            chk("rst_out",  res_out, 0);
        end

        run_op("add1", 1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("add2", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add3", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub1", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub2", 1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub3", 1'b1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Arbitration: both requesters valid continuously, consumer always ready.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0);
        drive_req(1'b1, 1'b1, 16'h0002, 16'h0002, 1'b0);
        res_ready = 1'b1;
        nres = 0; r0cnt = 0; r1cnt = 0; ids = '0;
        for (int c = 0; c < 80 && nres < 6; c++) begin
            #1;
            if (req0_ready) r0cnt++;
            if (req1_ready) r1cnt++;
            if (res_valid) begin
                ids[nres] = res_id;
                nres++;
            end
            if (nres < 6) @(negedge clk);
        end
        drive_req(1'b0, 1'b0, '0, '0, 1'b0);
        drive_req(1'b1, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk("arb_nres",  nres,  6);
        chk("arb_ids",   ids,   6'b101010);
        chk("arb_r0cnt", r0cnt, 3);
        chk("arb_r1cnt", r1cnt, 3);

        // Backpressure with a second req0 op pending behind the stalled result.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0);
        @(posedge clk);
        #1 drive_req(1'b0, 1'b1, 16'h0002, 16'h0003, 1'b0);
        wait_cnt = 0;
        @(negedge clk);
        while (!res_valid && wait_cnt < 20) begin
            wait_cnt++;
            @(negedge clk);
        end
        chk("bp_reached_done", res_valid, 1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_out",    res_out, 16'h0100);
            chk("bp_flags",  {res_valid, res_carry, res_ovf, res_id}, 4'b1000);
            chk("bp_readys", {req0_ready, req1_ready}, 2'b00);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_ready", req0_ready, 1);
        chk("bp_idle", res_valid, 0);
        @(posedge clk);
        #1 drive_req(1'b0, 1'b0, '0, '0, 1'b0);
        repeat (NIB) @(negedge clk);
        @(negedge clk);
        chk("bp2_valid", res_valid, 1);
        chk("bp2_out",   res_out,   16'h0005);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;

        // Reset mid-op: req0 granted (pointer moves to 1), then reset in RUN.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #1 drive_req(1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_out",   res_out,   0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("mid_rst_discard", res_valid, 0);
        end
        drive_req(1'b0, 1'b1, 16'h0010, 16'h0020, 1'b0);
        drive_req(1'b1, 1'b1, 16'h0100, 16'h0001, 1'b1);
        #1;
        chk("post_rst_gnt", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk);
        #1 drive_req(1'b0, 1'b0, '0, '0, 1'b0);
        drive_req(1'b1, 1'b0, '0, '0, 1'b0);
        repeat (NIB) @(negedge clk);
        @(negedge clk);
        chk("post_rst_valid", res_valid, 1);
        chk("post_rst_id",    res_id,    0);
        chk("post_rst_out",   res_out,   16'h0030);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
